// File: rtl/bus_burst_reader.sv
// bus_burst_reader
//   Read-only burst master for one arbiter controller port. A start command
//   issues sequential 32-bit word reads to one bank. Returned words go into a
//   show-ahead FIFO that a local consumer drains. Requests are credit-limited
//   so that outstanding reads plus buffered words never exceed FIFO_DEPTH.
//
//   Ports
//     i_clk, i_reset           clock, synchronous active-high reset
//     i_start, i_abort         burst start / abort commands
//     i_bank, i_address,       burst target, start byte address and word count
//     i_length                 (latched on start)
//     o_active, o_done         busy indicator, completion pulse
//     o_rd_valid, o_rd_data,   show-ahead consumer port
//     i_rd_ready
//     o_request, o_write,      arbiter request/busy/ack handshake
//     i_busy, i_ack, o_bank,   (o_request/o_bank/o_address are register-only)
//     o_address, o_data,
//     i_data
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_start; no bus traffic
//   ST_RUN   | issuing reads, buffering returned data
//   ST_FLUSH | aborted; FIFO cleared, draining outstanding acks
module bus_burst_reader #(
    parameter int ADDRESS_WIDTH = 26,
    parameter int LENGTH_WIDTH  = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [3:0]               i_bank,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [LENGTH_WIDTH-1:0]  i_length,
    output logic                     o_active,
    output logic                     o_done,
    output logic                     o_rd_valid,
    output logic [31:0]              o_rd_data,
    input  logic                     i_rd_ready,
    output logic                     o_request,
    output logic                     o_write,
    input  logic                     i_busy,
    input  logic                     i_ack,
    output logic [3:0]               o_bank,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [31:0]              o_data,
    input  logic [31:0]              i_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_done;
    logic                     w_done_next;

    logic [3:0]               r_bank;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [LENGTH_WIDTH-1:0]  r_remaining;
    logic [CW-1:0]            r_outstanding;

    logic [31:0]              r_mem [FIFO_DEPTH];
    logic [CW-1:0]            r_wptr;
    logic [CW-1:0]            r_rptr;

    logic [CW-1:0]            w_fifo_count;
    logic                     w_fifo_empty;
    logic                     w_credit_ok;
    logic                     w_request;
    logic                     w_accept;
    logic                     w_ack_ok;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_enter_run;
    logic                     w_enter_flush;

    // Extra pointer MSB distinguishes full from empty.
    assign w_fifo_count = r_wptr - r_rptr;
    assign w_fifo_empty = (r_wptr == r_rptr);

    // One extra bit so outstanding + count == FIFO_DEPTH cannot overflow.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count})
                         < (CW+1)'(FIFO_DEPTH);

    // Built from registers only: the arbiter derives i_busy from o_request.
    assign w_request = (r_state == ST_RUN) && (r_remaining != '0) && w_credit_ok;
    assign w_accept  = w_request && !i_busy;

    // Acks with nothing outstanding are stale (e.g. after reset) and dropped.
    assign w_ack_ok  = i_ack && (r_outstanding != '0);

    // Data acked in the abort cycle is discarded along with the FIFO.
    assign w_push    = (r_state == ST_RUN) && w_ack_ok && !i_abort;
    assign w_pop     = o_rd_valid && i_rd_ready;

    assign w_enter_run   = (r_state == ST_IDLE) && i_start && (i_length != '0);
    assign w_enter_flush = (r_state == ST_RUN) && i_abort;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_length != '0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_next = ST_FLUSH;
                end else if ((r_remaining == '0) && (r_outstanding == '0) && w_fifo_empty) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_outstanding == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank        <= '0;
            r_address     <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_enter_run) begin
                r_bank      <= i_bank;
                r_address   <= i_address & ~ADDRESS_WIDTH'(3);
                r_remaining <= i_length;
            end else if (w_accept) begin
                r_address   <= r_address + ADDRESS_WIDTH'(4);
                r_remaining <= r_remaining - LENGTH_WIDTH'(1);
            end

            case ({w_accept, w_ack_ok})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_enter_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= i_data;
        end
    end

    assign o_active   = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_rd_valid = !w_fifo_empty && (r_state != ST_FLUSH);
    assign o_rd_data  = r_mem[r_rptr[PW-1:0]];
    assign o_request  = w_request;
    assign o_write    = 1'b0;
    assign o_bank     = r_bank;
    assign o_address  = r_address;
    assign o_data     = 32'h0;

endmodule

// File: tb/tb_bus_burst_reader.sv
// Directed bench for bus_burst_reader: a bus model acks each accepted read
// two cycles later with data derived from the address; pops and accepted
// addresses are logged and compared against hand-computed values.
module tb_bus_burst_reader;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ack_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [3:0]  i_bank = '0;
    logic [25:0] i_address = '0;
    logic [15:0] i_length = '0;
    logic        o_active;
    logic        o_done;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        i_rd_ready = 1'b0;
    logic        o_request;
    logic        o_write;
    logic        i_busy = 1'b0;
    logic        i_ack = 1'b0;
    logic [3:0]  o_bank;
    logic [25:0] o_address;
    logic [31:0] o_data;
    logic [31:0] i_data = '0;

    ack_t        q_ack[$];
    logic [25:0] q_req[$];
    logic [31:0] q_pop[$];
    int          cyc = 0;
    int          n_done = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          hold = 1'b0;

    always #5 clk = ~clk;

    bus_burst_reader #(
        .ADDRESS_WIDTH(26),
        .LENGTH_WIDTH (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_bank     (i_bank),
        .i_address  (i_address),
        .i_length   (i_length),
        .o_active   (o_active),
        .o_done     (o_done),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .i_rd_ready (i_rd_ready),
        .o_request  (o_request),
        .o_write    (o_write),
        .i_busy     (i_busy),
        .i_ack      (i_ack),
        .o_bank     (o_bank),
        .o_address  (o_address),
        .o_data     (o_data),
        .i_data     (i_data)
    );

    function automatic logic [31:0] word_of(input logic [25:0] addr);
        return {6'h2A, addr};
    endfunction

    function automatic logic [25:0] addr_at(input logic [25:0] base, input int i);
        return base + 26'(4 * i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a falling edge: samples this cycle, steps one clock, then
    // drives the bus model's ack for the next cycle.
    task automatic tick();
        logic        acc;
        logic [25:0] acc_addr;
        acc      = o_request && !i_busy;
        acc_addr = o_address;
        if (o_done) n_done++;
        if (acc) q_req.push_back(acc_addr);
        if (o_rd_valid && i_rd_ready) q_pop.push_back(o_rd_data);
        @(posedge clk);
        cyc++;
        if (acc) q_ack.push_back('{cyc + 1, word_of(acc_addr)});
        #1;
        if (!hold && q_ack.size() > 0 && q_ack[0].due <= cyc) begin
            i_ack  = 1'b1;
            i_data = q_ack[0].data;
            void'(q_ack.pop_front());
        end else begin
            i_ack  = 1'b0;
            i_data = '0;
        end
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [3:0] b, input logic [25:0] a, input logic [15:0] l);
        i_bank    = b;
        i_address = a;
        i_length  = l;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!o_active) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_timeout"}, 64'(ok), 64'd1);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        q_req.delete();
        q_pop.delete();
        n_done = 0;
    endtask

    initial begin
        int bad;
        int spurious;
        @(negedge clk);

        // reset state
        i_reset = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        check("rst_active",  64'(o_active),   64'd0);
        check("rst_done",    64'(o_done),     64'd0);
        check("rst_request", 64'(o_request),  64'd0);
        check("rst_valid",   64'(o_rd_valid), 64'd0);
        check("rst_address", 64'(o_address),  64'd0);
        check("rst_bank",    64'(o_bank),     64'd0);
        check("rst_write",   64'(o_write),    64'd0);
        check("rst_data",    64'(o_data),     64'd0);

        // 1: basic burst
        clear_logs();
        i_rd_ready = 1'b1;
        start_burst(4'd3, 26'h0000100, 16'd4);
        check("t1_active",  64'(o_active),  64'd1);
        check("t1_bank",    64'(o_bank),    64'd3);
        check("t1_addr0",   64'(o_address), 64'h100);
        check("t1_request", 64'(o_request), 64'd1);
        run_idle("t1", 100);
        check("t1_nreq", 64'(q_req.size()), 64'd4);
        check("t1_npop", 64'(q_pop.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_req.size() && i < q_pop.size(); i++) begin
            check($sformatf("t1_req%0d", i), 64'(q_req[i]), 64'(addr_at(26'h100, i)));
            check($sformatf("t1_pop%0d", i), 64'(q_pop[i]), 64'(word_of(addr_at(26'h100, i))));
        end
        check("t1_ndone",  64'(n_done),    64'd1);
        check("t1_req_end", 64'(o_request), 64'd0);

        // 2: credit limit
        clear_logs();
        i_rd_ready = 1'b0;
        start_burst(4'd1, 26'h0000200, 16'd20);
        repeat (30) tick();
        check("t2_nreq_stall", 64'(q_req.size()), 64'd8);
        check("t2_req_low",    64'(o_request),    64'd0);
        check("t2_valid",      64'(o_rd_valid),   64'd1);
        check("t2_head",       64'(o_rd_data),    64'(word_of(26'h200)));
        i_rd_ready = 1'b1;
        run_idle("t2", 300);
        check("t2_nreq", 64'(q_req.size()), 64'd20);
        check("t2_npop", 64'(q_pop.size()), 64'd20);
        bad = 0;
        for (int i = 0; i < 20 && i < q_req.size() && i < q_pop.size(); i++) begin
            if (q_req[i] !== addr_at(26'h200, i)) bad++;
            if (q_pop[i] !== word_of(addr_at(26'h200, i))) bad++;
        end
        check("t2_bad_words", 64'(bad), 64'd0);
        check("t2_ndone", 64'(n_done), 64'd1);

        // 3: busy stall
        clear_logs();
        start_burst(4'd2, 26'h0000300, 16'd6);
        tick();
        tick();
        i_busy = 1'b1;
        repeat (5) tick();
        check("t3_addr_hold", 64'(o_address),    64'h308);
        check("t3_nreq_hold", 64'(q_req.size()), 64'd2);
        check("t3_req_high",  64'(o_request),    64'd1);
        i_busy = 1'b0;
        run_idle("t3", 100);
        check("t3_nreq", 64'(q_req.size()), 64'd6);
        if (q_req.size() > 2) check("t3_resume_addr", 64'(q_req[2]), 64'h308);
        check("t3_npop", 64'(q_pop.size()), 64'd6);

        // 4: zero length, address wrap
        clear_logs();
        start_burst(4'd0, 26'h0000400, 16'd0);
        check("t4_zl_done",   64'(o_done),   64'd1);
        check("t4_zl_active", 64'(o_active), 64'd0);
        repeat (3) tick();
        check("t4_zl_nreq",   64'(q_req.size()), 64'd0);
        check("t4_zl_done_end", 64'(o_done), 64'd0);
        clear_logs();
        start_burst(4'd5, 26'h3FFFFFF, 16'd2);
        run_idle("t4", 100);
        check("t4_wrap_nreq", 64'(q_req.size()), 64'd2);
        if (q_req.size() == 2) begin
            check("t4_wrap_a0", 64'(q_req[0]), 64'h3FFFFFC);
            check("t4_wrap_a1", 64'(q_req[1]), 64'h0000000);
        end
        check("t4_wrap_npop", 64'(q_pop.size()), 64'd2);

        // 5: abort after 3 accepts, 2 acks returned
        clear_logs();
        i_rd_ready = 1'b0;
        start_burst(4'd4, 26'h0000500, 16'd10);
        repeat (3) tick();
        i_busy = 1'b1;
        hold   = 1'b1;
        tick();
        check("t5_nreq",   64'(q_req.size()), 64'd3);
        check("t5_valid",  64'(o_rd_valid),   64'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("t5_flush_valid",  64'(o_rd_valid), 64'd0);
        check("t5_flush_req",    64'(o_request),  64'd0);
        check("t5_flush_active", 64'(o_active),   64'd1);
        i_busy     = 1'b0;
        hold       = 1'b0;
        i_rd_ready = 1'b1;
        run_idle("t5", 50);
        check("t5_ndone", 64'(n_done),       64'd0);
        check("t5_npop",  64'(q_pop.size()), 64'd0);
        check("t5_acks",  64'(q_ack.size()), 64'd0);
        check("t5_nreq_after", 64'(q_req.size()), 64'd3);
        clear_logs();
        start_burst(4'd4, 26'h0000580, 16'd2);
        run_idle("t5b", 100);
        check("t5b_npop", 64'(q_pop.size()), 64'd2);
        if (q_pop.size() == 2) check("t5b_pop1", 64'(q_pop[1]), 64'(word_of(26'h584)));
        check("t5b_ndone", 64'(n_done), 64'd1);

        // 6: reset mid-burst, spurious acks
        clear_logs();
        hold = 1'b1;
        start_burst(4'd6, 26'h0000600, 16'd10);
        repeat (3) tick();
        i_busy  = 1'b1;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_busy  = 1'b0;
        check("t6_active",  64'(o_active),   64'd0);
        check("t6_request", 64'(o_request),  64'd0);
        check("t6_address", 64'(o_address),  64'd0);
        check("t6_bank",    64'(o_bank),     64'd0);
        check("t6_valid",   64'(o_rd_valid), 64'd0);
        check("t6_done",    64'(o_done),     64'd0);
        check("t6_pending", 64'(q_ack.size()), 64'd3);
        hold = 1'b0;
        spurious = 0;
        repeat (6) begin
            tick();
            if (o_rd_valid) spurious++;
        end
        check("t6_spurious", 64'(spurious),     64'd0);
        check("t6_acks",     64'(q_ack.size()), 64'd0);
        clear_logs();
        start_burst(4'd7, 26'h0000700, 16'd1);
        run_idle("t6b", 100);
        check("t6b_nreq", 64'(q_req.size()), 64'd1);
        check("t6b_npop", 64'(q_pop.size()), 64'd1);
        if (q_pop.size() == 1) check("t6b_pop0", 64'(q_pop[0]), 64'(word_of(26'h700)));
        check("t6b_ndone", 64'(n_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
